simeck_rev_keygen: RTL
======================

Name: simeck_rev_keygen

Overview:
- Decryption-side Simeck key schedule generator: produces round keys in reverse order (k[ROUNDS-1] down to k[0]) for the round datapath of the decrypter.
- On start it loads the 4-word master key and runs the forward schedule for ROUNDS cycles to reach the final key window. It then runs the schedule backwards, one key per accepted handshake.
- Round-constant bit z is supplied externally from the shared z-sequence table, indexed by rnd_idx.

Parameters:
- DATAW, 16, word width in bits (16 = Simeck32/64).
- ROUNDS, 32, number of round keys generated; must be >= 4.
- CW, 6, round-counter width; must satisfy 2^CW > ROUNDS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE.
- key  in  4*DATAW  master key. key[DATAW-1:0]=k0, key[2*DATAW-1:DATAW]=k1, key[3*DATAW-1:2*DATAW]=k2, key[4*DATAW-1:3*DATAW]=k3.
- z_bit  in  1  constant bit z[rnd_idx]; combinational from the table in the same cycle.
- rnd_idx  out  CW  current schedule index driving the z lookup.
- rkey  out  DATAW  registered round key.
- rkey_valid  out  1  rkey holds an unconsumed key.
- rkey_ready  in  1  consumer accepts rkey this cycle when rkey_valid=1.
- busy  out  1  high in FWD and REV.
- done  out  1  one-cycle pulse after the last key (k0) is accepted.

Behaviour:
- Datapath:
  - 4-word window t0..t3 (t0 oldest).
  - f(x) = (x & rotl(x,5)) ^ rotl(x,1).
  - Constant word cz = {all-ones[DATAW-1:2], 1'b0, z_bit}, i.e. (2^DATAW-4) ^ z.
- Forward step (index i):
  - t0<=t1, t1<=t2, t2<=t3, t3<=t0 ^ f(t1) ^ cz.
- Reverse step (index i, window = k[i+1..i+4]):
  - knew = t3 ^ f(t0) ^ cz.
  - t3<=t2, t2<=t1, t1<=t0, t0<=knew; rkey<=knew.
- States: IDLE, FWD, REV.
- IDLE:
  - busy=0, rkey_valid=0, rnd_idx=0.
  - start=1 at edge E0: window<=key, counter<=0, go to FWD.
- FWD:
  - One forward step per cycle with rnd_idx = 0..ROUNDS-1.
  - The step at index ROUNDS-1 (edge E_ROUNDS) sets counter<=ROUNDS-1 and goes to REV.
  - No output is produced.
- REV:
  - rnd_idx counts down from ROUNDS-1.
  - Perform a reverse step when (!rkey_valid || rkey_ready) and keys remain: rkey<=knew, rkey_valid<=1, then decrement the counter.
  - After index 0 has been produced, no further steps are taken.
  - When k0 is held and the consumer accepts it: rkey_valid<=0, done<=1 for one cycle, go to IDLE.
  - If rkey_valid=1 and rkey_ready=0, then rkey, the window and the counter all hold.
- Latency:
  - The first rkey_valid is seen high after edge E_(ROUNDS+1).
  - With rkey_ready held high: one key per cycle; done is high after edge E_(2*ROUNDS+1).
- start outside IDLE is ignored.
- key is sampled only at the start edge; later changes to key have no effect.
- Reset (any state, including mid-FWD or REV) returns to IDLE: window=0, counter=0, rkey=0, rkey_valid=0, busy=0, done=0.
- All arithmetic is XOR/AND/rotate on DATAW bits; there are no carries.
- The counter never wraps: it saturates at 0 in REV.

Test Plan:
- Simeck32/64 vector, key=0x1918_1110_0908_0100, rkey_ready=1 -> 32 keys emitted in consecutive cycles, matching a software model of k31..k0 in order. The last four are 0x1918, 0x1110, 0x0908, 0x0100. done pulses once, one cycle after 0x0100 is accepted.
- Same key with rkey_ready toggled pseudo-randomly -> identical key sequence, no drops or duplicates. rkey is stable while valid&&!ready. rnd_idx is observed 31..0 in REV.
- start asserted again during FWD and during REV with a different key -> ignored; the output sequence is unchanged from the first key.
- reset pulsed mid-REV, after 10 keys -> next cycle: rkey_valid=0, busy=0, rkey=0. A new start with key=0 -> 32 keys matching the model for the all-zero key.
- Timing check: start at cycle 0 -> busy high from cycle 1, first rkey_valid at cycle ROUNDS+1=33. rnd_idx sequence is 0..31 then 31..0.
- Back-to-back: start issued the cycle after done -> accepted, full sequence regenerated correctly.

Source files
------------

// File: rtl/simeck_rev_keygen_if.sv
// rtl/simeck_rev_keygen_if.sv - handshake bundle between the reverse key generator and its consumer
interface simeck_rev_keygen_if #(
    parameter int DATAW = 16,
    parameter int CW    = 6
);
    logic               start;
    logic [4*DATAW-1:0] key;
    logic               z_bit;
    logic [CW-1:0]      rnd_idx;
    logic [DATAW-1:0]   rkey;
    logic               rkey_valid;
    logic               rkey_ready;
    logic               busy;
    logic               done;

    modport master (
        output start, key, z_bit, rkey_ready,
        input  rnd_idx, rkey, rkey_valid, busy, done
    );

    modport slave (
        input  start, key, z_bit, rkey_ready,
        output rnd_idx, rkey, rkey_valid, busy, done
    );
endinterface

// File: rtl/simeck_rev_keygen.sv
// rtl/simeck_rev_keygen.sv - Simeck key schedule run forward to the end, then replayed backwards one key per handshake
module simeck_rev_keygen #(
    parameter int DATAW  = 16,
    parameter int ROUNDS = 32,
    parameter int CW     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    simeck_rev_keygen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(ROUNDS - 1);

    state_t           state, state_nxt;
    logic [DATAW-1:0] t0, t1, t2, t3;
    logic [DATAW-1:0] rkey_q;
    logic [CW-1:0]    cnt;
    logic             rkey_valid_q;
    logic             done_q;
    logic             exhausted;
    logic [DATAW-1:0] cz, fwd_new, rev_new;
    logic             rev_step, rev_finish;

    function automatic logic [DATAW-1:0] f(input logic [DATAW-1:0] x);
        return (x & {x[DATAW-6:0], x[DATAW-1:DATAW-5]}) ^ {x[DATAW-2:0], x[DATAW-1]};
    endfunction

    assign cz      = {{(DATAW-2){1'b1}}, 1'b0, bus.z_bit};
    assign fwd_new = t0 ^ f(t1) ^ cz;
    assign rev_new = t3 ^ f(t0) ^ cz;

    // exhausted marks that k0 has been produced; the counter itself parks at 0
    assign rev_step   = (state == REV) && !exhausted && (!rkey_valid_q || bus.rkey_ready);
    assign rev_finish = (state == REV) && exhausted && rkey_valid_q && bus.rkey_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FWD;
            FWD:     if (cnt == LAST_IDX) state_nxt = REV;
            REV:     if (rev_finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state != IDLE);
        bus.rnd_idx = (state == IDLE) ? '0 : cnt;
    end

    assign bus.rkey       = rkey_q;
    assign bus.rkey_valid = rkey_valid_q;
    assign bus.done       = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            t0 <= '0; t1 <= '0; t2 <= '0; t3 <= '0;
            cnt          <= '0;
            rkey_q       <= '0;
            rkey_valid_q <= 1'b0;
            done_q       <= 1'b0;
            exhausted    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        t0 <= bus.key[DATAW-1:0];
                        t1 <= bus.key[2*DATAW-1:DATAW];
                        t2 <= bus.key[3*DATAW-1:2*DATAW];
                        t3 <= bus.key[4*DATAW-1:3*DATAW];
                        cnt       <= '0;
                        exhausted <= 1'b0;
                    end
                end
                FWD: begin
                    t0 <= t1; t1 <= t2; t2 <= t3; t3 <= fwd_new;
                    if (cnt != LAST_IDX) cnt <= cnt + CW'(1);
                end
                REV: begin
                    if (rev_step) begin
                        t3 <= t2; t2 <= t1; t1 <= t0; t0 <= rev_new;
                        rkey_q       <= rev_new;
                        rkey_valid_q <= 1'b1;
                        if (cnt == '0) exhausted <= 1'b1;
                        else           cnt <= cnt - CW'(1);
                    end else if (rev_finish) begin
                        rkey_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
